bist_controller: RTL
====================

// Module: bist_controller
// PURPOSE
//  On-chip logic BIST engine. It is the responder to the pin-level bistmode/bistdone/bistpass protocol.
//  It sits between the chip pins and the CUT.
//  - bistmode=0: pins drive the CUT directly (system mode).
//  - bistmode=1: a 35-bit LFSR drives the CUT inputs, and a 49-bit MISR compacts the CUT outputs.
//  - At the end of the run, the signature is compared against a golden value, and bistdone/bistpass are raised.
// PARAMETERS
//  PI_W         35                   CUT primary-input width
//  PO_W         49                   CUT primary-output width
//  NUM_PATTERNS 2000                 patterns applied per run; must be >=1
//  LFSR_SEED    35'h0_0000_0001      LFSR load value; must be nonzero
//  LFSR_TAPS    35'h5_0000_0000      Fibonacci feedback mask (x^35+x^33+1)
//  MISR_TAPS    49'h1_0080_0000_0000 MISR feedback mask (x^49+x^40+1)
//  GOLDEN_SIG   49'h0                fault-free signature; set per CUT from simulation
// PORTS
//  clk       in   1     system clock; every flop is on the rising edge
//  rst       in   1     synchronous, active-high reset
//  bistmode  in   1     1 = run BIST; 0 = system mode
//  pi_ext    in   PI_W  primary inputs from the pins
//  cut_po    in   PO_W  CUT primary outputs, sampled into the MISR
//  cut_pi    out  PI_W  CUT primary inputs
//  cut_rst   out  1     CUT reset, = rst | (state==INIT)
//  bistdone  out  1     run complete (registered)
//  bistpass  out  1     signature matched GOLDEN_SIG; valid while bistdone=1 (registered)
// BEHAVIOUR
//  Reset values: state=IDLE, lfsr=LFSR_SEED, misr=0, cnt=0, bistdone=0, bistpass=0.
//  cut_pi mux (combinational): lfsr when state is INIT, RUN or FLUSH; otherwise pi_ext.
//  LFSR step: lfsr <= {lfsr[PI_W-2:0], ^(lfsr & LFSR_TAPS)}. It advances only in RUN.
//  MISR step: misr <= {misr[PO_W-2:0], ^(misr & MISR_TAPS)} ^ cut_po. It steps only in RUN and FLUSH.
//  cnt width is $clog2(NUM_PATTERNS+1). It counts RUN cycles and is cleared in INIT.
//  FSM transitions:
//   IDLE  -> INIT  when bistmode=1. Stays in IDLE otherwise.
//   INIT  -> RUN   unconditionally. Loads lfsr=LFSR_SEED, misr=0, cnt=0; cut_rst=1.
//   RUN   -> FLUSH when cnt==NUM_PATTERNS-1. Otherwise cnt++.
//   FLUSH -> DONE  unconditionally. Absorbs the response to the last pattern.
//           On this edge: bistpass <= (misr_next==GOLDEN_SIG), bistdone <= 1.
//   DONE  holds bistdone/bistpass until rst=1 or bistmode=0.
//  Latency: bistdone rises on the (NUM_PATTERNS+3)th rising edge after the first edge with rst=0 and bistmode=1.
//  bistmode=0 in any non-IDLE state: next edge goes to IDLE with bistdone=0 and bistpass=0. Run aborted, no partial result.
//  rst mid-run: next edge gives the full reset values. bistdone falls, so the next run gives a fresh 0->1 edge for the bench.
//  rst has priority over bistmode at every edge.
//  A rerun after DONE requires rst=1 or bistmode=0 first. The controller never self-restarts.
//  With bistmode held at 1, a run is deterministic: the same CUT gives the same signature every run.
// CONFIGURATION
//  BIST_SIG_OUT_EN defined:
//   - Adds output port misr_sig [PO_W-1:0], driven by the current MISR register.
//   - In DONE it holds the final signature; use it to characterise GOLDEN_SIG and for fault diagnosis.
//  BIST_SIG_OUT_EN undefined:
//   - The port is absent; the MISR is internal only.
//   - All other behaviour is identical.
// TESTING  (bench: NUM_PATTERNS=8, CUT stub cut_po = {14'b0, cut_pi} registered 1 cycle)
//  1. Reset/bypass: rst=1 for 2 edges, bistmode=0, pi_ext=35'h1_2345_6789.
//     -> bistdone=0, bistpass=0, cut_pi=35'h1_2345_6789 in the same cycle, cut_rst=1 only while rst=1.
//  2. Fault-free run: bistmode=1, rst released; GOLDEN_SIG from the bench reference model.
//     -> bistdone=1 exactly on edge 11 after release; bistpass=1. cut_rst=1 for the single INIT cycle.
//  3. Stuck-at: force stub cut_po[0]=1 during RUN.
//     -> bistdone=1 on edge 11, bistpass=0. With BIST_SIG_OUT_EN: misr_sig != GOLDEN_SIG.
//  4. Reset mid-run: rst=1 at RUN cycle 4, then released.
//     -> bistdone=0 next edge; the rerun completes 11 edges later with a signature identical to scenario 2.
//  5. Abort: bistmode drops to 0 at RUN cycle 3.
//     -> state=IDLE next edge, bistdone=0, cut_pi follows pi_ext. Raising bistmode again starts a full run.
//  6. Back-to-back: two runs separated by a 1-cycle rst.
//     -> bistdone shows 1->0->1, and both runs give identical bistpass.

Source files
------------

// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - logic BIST engine: LFSR pattern source, MISR compactor, golden compare.
// Optional BIST_SIG_OUT_EN exposes the live MISR register on misr_sig.
module bist_controller #(
    parameter int             PI_W         = 35,
    parameter int             PO_W         = 49,
    parameter int             NUM_PATTERNS = 2000,
    parameter logic [PI_W-1:0] LFSR_SEED   = 35'h0_0000_0001,
    parameter logic [PI_W-1:0] LFSR_TAPS   = 35'h5_0000_0000,
    parameter logic [PO_W-1:0] MISR_TAPS   = 49'h1_0080_0000_0000,
    parameter logic [PO_W-1:0] GOLDEN_SIG  = 49'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bistmode,
    input  logic [PI_W-1:0] pi_ext,
    input  logic [PO_W-1:0] cut_po,
    output logic [PI_W-1:0] cut_pi,
    output logic            cut_rst,
    output logic            bistdone,
`ifdef BIST_SIG_OUT_EN
    output logic [PO_W-1:0] misr_sig,
`endif
    output logic            bistpass
);

    localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PATTERNS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] INIT  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [PI_W-1:0]  lfsr_q, lfsr_d, lfsr_step;
    logic [PO_W-1:0]  misr_q, misr_d, misr_step;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    assign lfsr_step = {lfsr_q[PI_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    assign misr_step = {misr_q[PO_W-2:0], ^(misr_q & MISR_TAPS)} ^ cut_po;

    assign cut_pi   = (state_q == INIT || state_q == RUN || state_q == FLUSH) ? lfsr_q : pi_ext;
    assign cut_rst  = rst | (state_q == INIT);
    assign bistdone = done_q;
    assign bistpass = pass_q;
`ifdef BIST_SIG_OUT_EN
    assign misr_sig = misr_q;
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        // Dropping bistmode anywhere outside IDLE aborts with no partial result.
        if (state_q != IDLE && !bistmode) begin
            state_d = IDLE;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    if (bistmode) state_d = INIT;
                end
                INIT: begin
                    lfsr_d  = LFSR_SEED;
                    misr_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
                RUN: begin
                    lfsr_d = lfsr_step;
                    misr_d = misr_step;
                    if (cnt_q == CNT_LAST) state_d = FLUSH;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
                FLUSH: begin
                    // One extra MISR step absorbs the response to the last pattern.
                    misr_d  = misr_step;
                    done_d  = 1'b1;
                    pass_d  = (misr_step == GOLDEN_SIG);
                    state_d = DONE;
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

endmodule
